// File: rtl/eth_pkg.sv
// Shared widths and state encoding for the Ethernet buffer read path.
// Defaults match the 1024x8 transmit data buffer.
package eth_pkg;

   localparam int ETH_RAM_AW = 10;
   localparam int ETH_DW     = 8;
   localparam int ETH_LEN_W  = 11;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      READ  = 2'd1,
      DRAIN = 2'd2,
      DONE  = 2'd3
   } rd_state_t;

endpackage

// File: rtl/eth_rd_prefetch_fifo.sv
// Small first-word-fall-through FIFO that decouples buffer RAM reads
// from the transmit stream handshake.
module eth_rd_prefetch_fifo #(
   parameter int DW    = 8,
   parameter int DEPTH = 4,
   localparam int AW   = $clog2(DEPTH)
) (
   input  logic          i_clk,
   input  logic          i_rst_n,
   input  logic          i_push,
   input  logic [DW-1:0] i_pushData,
   input  logic          i_pop,
   output logic [DW-1:0] o_head,
   output logic [AW:0]   o_count,
   output logic          o_empty,
   output logic          o_full
);

   logic [DW-1:0] mem [DEPTH];
   logic [AW-1:0] wrIdx;
   logic [AW-1:0] rdIdx;
   logic [AW:0]   count;
   logic          pushOk;
   logic          popOk;

   assign o_empty = (count == '0);
   assign o_full  = (count == (AW+1)'(DEPTH));
   assign o_count = count;
   assign o_head  = mem[rdIdx];

   // A push into a full FIFO is still fine when the head leaves in the same cycle.
   assign pushOk = i_push && (!o_full || i_pop);
   assign popOk  = i_pop && !o_empty;

   always_ff @(posedge i_clk) begin
      if (pushOk) begin
         mem[wrIdx] <= i_pushData;
      end
   end

   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         wrIdx <= '0;
         rdIdx <= '0;
         count <= '0;
      end else begin
         if (pushOk) begin
            wrIdx <= wrIdx + 1'b1;
         end
         if (popOk) begin
            rdIdx <= rdIdx + 1'b1;
         end
         count <= count + (AW+1)'(pushOk) - (AW+1)'(popOk);
      end
   end

endmodule

// File: rtl/eth_frame_reader.sv
// Streams a frame of bytes out of the Ethernet buffer RAM toward the MAC TX
// path, prefetching through a small FIFO to hide read latency and stalls.
module eth_frame_reader
   import eth_pkg::*;
#(
   parameter int ADDR_W = ETH_RAM_AW,
   parameter int DATA_W = ETH_DW,
   parameter int LEN_W  = ETH_LEN_W
) (
   input  logic              i_clk,
   input  logic              i_rst_n,
   input  logic              i_start,
   input  logic [ADDR_W-1:0] i_base_addr,
   input  logic [LEN_W-1:0]  i_frame_len,
   output logic              o_busy,
   output logic              o_done,
   output logic              o_rd_en,
   output logic [ADDR_W-1:0] o_rd_addr,
   input  logic [DATA_W-1:0] i_rd_data,
   output logic [DATA_W-1:0] o_tx_data,
   output logic              o_tx_valid,
   output logic              o_tx_last,
   input  logic              i_tx_ready
);

   localparam logic [LEN_W-1:0] MAX_LEN = LEN_W'(2**ADDR_W);

   rd_state_t         state;
   logic [ADDR_W-1:0] rdPtr;
   logic [LEN_W-1:0]  remaining;
   logic [LEN_W-1:0]  sent;
   logic [LEN_W-1:0]  frameLen;
   logic              busyReg;
   logic              doneReg;
   logic              inflight;

   logic [LEN_W-1:0]  startLen;
   logic [DATA_W-1:0] fifoHead;
   logic [2:0]        fifoCount;
   logic              fifoEmpty;
   logic              fifoFull;
   logic [3:0]        occupancy;
   logic              rdEn;
   logic              txValid;
   logic              txLast;
   logic              txFire;

   assign startLen = (i_frame_len > MAX_LEN) ? MAX_LEN : i_frame_len;

   // Issue only while the FIFO can absorb every outstanding byte; the decision
   // looks at registers alone so the stream ready never reaches the RAM port.
   assign occupancy = {1'b0, fifoCount} + {3'b000, inflight};
   assign rdEn      = (state == READ) && (remaining != '0) && !fifoFull &&
                      (occupancy <= 4'd2);

   assign txValid = !fifoEmpty;
   assign txLast  = txValid && (sent == frameLen - 1'b1);
   assign txFire  = txValid && i_tx_ready;

   eth_rd_prefetch_fifo #(
      .DW    (DATA_W),
      .DEPTH (4)
   ) prefetchFifo (
      .i_clk      (i_clk),
      .i_rst_n    (i_rst_n),
      .i_push     (inflight),
      .i_pushData (i_rd_data),
      .i_pop      (txFire),
      .o_head     (fifoHead),
      .o_count    (fifoCount),
      .o_empty    (fifoEmpty),
      .o_full     (fifoFull)
   );

   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         state     <= IDLE;
         rdPtr     <= '0;
         remaining <= '0;
         sent      <= '0;
         frameLen  <= '0;
         busyReg   <= 1'b0;
         doneReg   <= 1'b0;
         inflight  <= 1'b0;
      end else begin
         inflight <= rdEn;
         doneReg  <= 1'b0;
         if (txFire) begin
            sent <= sent + 1'b1;
         end
         if (rdEn) begin
            rdPtr     <= rdPtr + 1'b1;
            remaining <= remaining - 1'b1;
         end
         case (state)
            IDLE: begin
               if (i_start) begin
                  rdPtr     <= i_base_addr;
                  remaining <= startLen;
                  frameLen  <= startLen;
                  sent      <= '0;
                  busyReg   <= 1'b1;
                  if (startLen == '0) begin
                     state   <= DONE;
                     doneReg <= 1'b1;
                  end else begin
                     state <= READ;
                  end
               end
            end
            READ: begin
               if (rdEn && (remaining == LEN_W'(1))) begin
                  state <= DRAIN;
               end
            end
            DRAIN: begin
               // Leaving on the accepted last beat puts o_done in the very next cycle.
               if (txFire && txLast) begin
                  state   <= DONE;
                  doneReg <= 1'b1;
               end
            end
            DONE: begin
               busyReg <= 1'b0;
               state   <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign o_busy     = busyReg;
   assign o_done     = doneReg;
   assign o_rd_en    = rdEn;
   assign o_rd_addr  = rdPtr;
   assign o_tx_valid = txValid;
   assign o_tx_last  = txLast;
   // Masked so the stream data reads as zero whenever nothing is offered.
   assign o_tx_data  = txValid ? fifoHead : '0;

endmodule

// File: tb/tb_eth_frame_reader.sv
// Directed bench for eth_frame_reader: RAM model, stream monitor and
// per-frame latency/ordering checks against hand-derived cycle numbers.
module tb_eth_frame_reader;

   logic        i_clk = 1'b0;
   logic        i_rst_n = 1'b0;
   logic        i_start = 1'b0;
   logic [9:0]  i_base_addr = '0;
   logic [10:0] i_frame_len = '0;
   logic        o_busy, o_done, o_rd_en, o_tx_valid, o_tx_last;
   logic [9:0]  o_rd_addr;
   logic [7:0]  i_rd_data;
   logic [7:0]  o_tx_data;
   logic        i_tx_ready = 1'b1;

   logic [7:0]  ram [1024];
   logic [7:0]  ramQ = '0;

   int total = 0;
   int bad = 0;
   int cyc = 0;
   int kEdge = 0;

   int  expBase = 0, expLen = 0;
   int  readIdx = 0, beatIdx = 0, doneCount = 0;
   int  firstRdCyc = -1, lastRdCyc = -1, firstBeatCyc = -1, lastAcceptCyc = -1, doneCyc = -1;
   bit  frameActive = 1'b0;
   bit  stallPrev = 1'b0;
   logic [7:0] prevData = '0;
   logic prevLast = 1'b0;
   int  readyMode = 0;
   int  readyStep = 0;

   eth_frame_reader dut (
      .i_clk       (i_clk),
      .i_rst_n     (i_rst_n),
      .i_start     (i_start),
      .i_base_addr (i_base_addr),
      .i_frame_len (i_frame_len),
      .o_busy      (o_busy),
      .o_done      (o_done),
      .o_rd_en     (o_rd_en),
      .o_rd_addr   (o_rd_addr),
      .i_rd_data   (i_rd_data),
      .o_tx_data   (o_tx_data),
      .o_tx_valid  (o_tx_valid),
      .o_tx_last   (o_tx_last),
      .i_tx_ready  (i_tx_ready)
   );

   always #5 i_clk = ~i_clk;
   always @(posedge i_clk) cyc <= cyc + 1;

   // Buffer RAM: registered read, data one cycle after the enable.
   always @(posedge i_clk) if (o_rd_en) ramQ <= ram[o_rd_addr];
   assign i_rd_data = ramQ;

   task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=%0h expected=%0h (cyc=%0d)", tag, got, exp, cyc);
      end
   endtask

   always @(posedge i_clk) begin
      #1;
      if (readyMode == 0) begin
         i_tx_ready = 1'b1;
      end else begin
         if (readyStep < 4) i_tx_ready = (readyStep % 2 == 0);
         else               i_tx_ready = 1'($urandom_range(0, 1));
         readyStep++;
      end
   end

   always @(negedge i_clk) begin
      if (!i_rst_n) begin
         stallPrev = 1'b0;
      end else begin
         if (frameActive) checkVal("occupancy", 32'(readIdx - beatIdx <= 3), 1);
         if (o_rd_en) begin
            checkVal("read_in_range", 32'(frameActive && readIdx < expLen), 1);
            if (readIdx < expLen) checkVal("rd_addr", 32'(o_rd_addr), 32'((expBase + readIdx) % 1024));
            if (readIdx == 0) firstRdCyc = cyc;
            lastRdCyc = cyc;
            readIdx++;
         end
         if (stallPrev) begin
            checkVal("hold_valid", 32'(o_tx_valid), 1);
            checkVal("hold_data", 32'(o_tx_data), 32'(prevData));
            checkVal("hold_last", 32'(o_tx_last), 32'(prevLast));
         end
         if (o_tx_valid && i_tx_ready) begin
            checkVal("beat_in_range", 32'(frameActive && beatIdx < expLen), 1);
            if (beatIdx < expLen) begin
               checkVal("beat_data", 32'(o_tx_data), 32'(ram[(expBase + beatIdx) % 1024]));
               checkVal("beat_last", 32'(o_tx_last), 32'(beatIdx == expLen - 1));
            end
            if (beatIdx == 0) firstBeatCyc = cyc;
            if (o_tx_last) lastAcceptCyc = cyc;
            beatIdx++;
         end
         stallPrev = o_tx_valid && !i_tx_ready;
         prevData  = o_tx_data;
         prevLast  = o_tx_last;
         if (o_done) begin
            doneCount++;
            doneCyc = cyc;
         end
      end
   end

   task automatic armFrame(input int base, input int len);
      expBase = base;
      expLen = (len > 1024) ? 1024 : len;
      readIdx = 0; beatIdx = 0; doneCount = 0;
      firstRdCyc = -1; lastRdCyc = -1; firstBeatCyc = -1; lastAcceptCyc = -1; doneCyc = -1;
      frameActive = 1'b1;
   endtask

   // Called just after a rising edge; start is sampled at the next edge.
   task automatic pulseStart(input int base, input int len);
      i_start = 1'b1;
      i_base_addr = 10'(base);
      i_frame_len = 11'(len);
      @(posedge i_clk); #1;
      i_start = 1'b0;
      kEdge = cyc;
      checkVal("busy_after_start", 32'(o_busy), 1);
   endtask

   task automatic finishFrame(input string name, input int budget);
      int n = 0;
      while (doneCount == 0 && n < budget) begin
         @(posedge i_clk); #1;
         n++;
      end
      checkVal({name, "_done_seen"}, 32'(doneCount), 1);
      checkVal({name, "_reads"}, 32'(readIdx), 32'(expLen));
      checkVal({name, "_beats"}, 32'(beatIdx), 32'(expLen));
      checkVal({name, "_busy_low"}, 32'(o_busy), 0);
      frameActive = 1'b0;
      $display("frame %s base=%03h len=%0d reads=%0d beats=%0d done_cyc=%0d", name, expBase, expLen,
               readIdx, beatIdx, doneCyc - kEdge);
   endtask

   task automatic checkTiming(input string name);
      checkVal({name, "_first_rd"}, 32'(firstRdCyc), 32'(kEdge));
      checkVal({name, "_last_rd"}, 32'(lastRdCyc), 32'(kEdge + expLen - 1));
      checkVal({name, "_first_beat"}, 32'(firstBeatCyc), 32'(kEdge + 2));
      checkVal({name, "_last_accept"}, 32'(lastAcceptCyc), 32'(kEdge + 1 + expLen));
      checkVal({name, "_done_cyc"}, 32'(doneCyc), 32'(kEdge + 2 + expLen));
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      int n;
      for (int a = 0; a < 1024; a++) ram[a] = 8'((a * 37 + 5) ^ (a >> 3));
      ram[0] = 8'h11; ram[1] = 8'h22; ram[2] = 8'h33; ram[3] = 8'h44;

      repeat (3) @(posedge i_clk);
      @(negedge i_clk);
      checkVal("reset_outputs", 32'({o_busy, o_done, o_rd_en, o_rd_addr, o_tx_data, o_tx_valid, o_tx_last}), 0);
      @(posedge i_clk); #1;
      i_rst_n = 1'b1;
      repeat (2) @(posedge i_clk);
      #1;

      // 1: nominal four-byte frame
      armFrame(0, 4); pulseStart(0, 4);
      finishFrame("nominal", 50); checkTiming("nominal");

      // 2: address wrap
      armFrame(10'h3FE, 4); pulseStart(10'h3FE, 4);
      finishFrame("wrap", 50); checkTiming("wrap");

      // 3: backpressure
      readyMode = 1; readyStep = 0;
      armFrame(10'h040, 8); pulseStart(10'h040, 8);
      finishFrame("backpressure", 200);
      readyMode = 0;
      @(posedge i_clk); #1;

      // 4: length edges
      armFrame(10'h055, 0); pulseStart(10'h055, 0);
      finishFrame("len0", 20);
      checkVal("len0_done_cyc", 32'(doneCyc), 32'(kEdge));
      armFrame(10'h100, 1500); pulseStart(10'h100, 1500);
      finishFrame("len1500", 1200);
      checkVal("len1500_beats", 32'(beatIdx), 1024);
      armFrame(10'h200, 1024); pulseStart(10'h200, 1024);
      finishFrame("len1024", 1200); checkTiming("len1024");

      // 5: start while busy, start in the done cycle
      armFrame(10'h010, 6); pulseStart(10'h010, 6);
      @(posedge i_clk); #1;
      i_start = 1'b1; i_base_addr = 10'h300; i_frame_len = 11'd3;
      @(posedge i_clk); #1;
      i_start = 1'b0;
      n = 0;
      while (cyc < kEdge + 2 + 6 && n < 50) begin
         @(posedge i_clk); #1;
         n++;
      end
      checkVal("done_cycle_reached", 32'(o_done), 1);
      i_start = 1'b1; i_base_addr = 10'h3F0; i_frame_len = 11'd2;
      @(posedge i_clk); #1;
      i_start = 1'b0;
      checkVal("start_in_done_ignored", 32'(o_busy), 0);
      finishFrame("busy_start", 10); checkTiming("busy_start");
      armFrame(10'h020, 3); pulseStart(10'h020, 3);
      finishFrame("after_done", 50); checkTiming("after_done");

      // 6: reset mid-frame
      armFrame(10'h080, 8); pulseStart(10'h080, 8);
      n = 0;
      while (beatIdx < 3 && n < 50) begin
         @(posedge i_clk); #1;
         n++;
      end
      checkVal("pre_reset_beats", 32'(beatIdx), 3);
      i_rst_n = 1'b0;
      @(posedge i_clk);
      @(negedge i_clk);
      checkVal("abort_outputs", 32'({o_busy, o_done, o_rd_en, o_rd_addr, o_tx_data, o_tx_valid, o_tx_last}), 0);
      @(posedge i_clk); #1;
      frameActive = 1'b0; doneCount = 0;
      i_rst_n = 1'b1;
      repeat (6) @(posedge i_clk);
      #1;
      checkVal("abort_no_done", 32'(doneCount), 0);
      checkVal("abort_idle", 32'(o_busy), 0);
      armFrame(10'h3FC, 5); pulseStart(10'h3FC, 5);
      finishFrame("post_reset", 50); checkTiming("post_reset");

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/eth_frame_reader.md
Name: eth_frame_reader

Overview:
- Read-side master for the 1024x8 Ethernet data buffer RAM: address, clock-enable and data ports, unregistered output with 1-cycle read latency.
- On a start command, streams a frame of N bytes from a base address over a byte stream with valid/ready handshake toward the MAC TX path.
- Hides RAM read latency and absorbs downstream backpressure with a small prefetch FIFO.
- Sits between the buffer RAM read port and the Ethernet transmit framer.

Parameters:
- ADDR_W, 10, RAM address width (depth 2^ADDR_W)
- DATA_W, 8, RAM/stream byte width
- LEN_W, 11, frame length width (must hold 2^ADDR_W)

Ports:
- i_clk  in  1  single clock; RAM read clock is the same net
- i_rst_n  in  1  synchronous active-low reset
- i_start  in  1  one-cycle start pulse, sampled only in IDLE
- i_base_addr  in  ADDR_W  first byte address, captured on accepted start
- i_frame_len  in  LEN_W  byte count, captured on accepted start
- o_busy  out  1  high from accepted start until done
- o_done  out  1  one-cycle completion pulse
- o_rd_en  out  1  RAM read clock enable
- o_rd_addr  out  ADDR_W  RAM read address
- i_rd_data  in  DATA_W  RAM read data, valid the cycle after the o_rd_en cycle
- o_tx_data  out  DATA_W  stream byte
- o_tx_valid  out  1  stream valid
- o_tx_last  out  1  marks final byte of frame, qualified by o_tx_valid
- i_tx_ready  in  1  stream ready

Behaviour:
- Reset (i_rst_n low at edge): all outputs 0, FIFO emptied, in-flight read discarded, state IDLE. Reset mid-frame aborts with no o_done.
- Length rule: len = min(i_frame_len, 2^ADDR_W). len==0 means no reads, no beats, o_done one cycle after start.
- States:
  - IDLE: i_start=1 captures rd_ptr<=base, remaining<=len, sent<=0, o_busy<=1, then goes to READ, or to DONE if len==0. i_start is ignored outside IDLE.
  - READ: o_rd_en = (remaining>0) && (fifo_count + inflight <= 2), combinational from registers only, with no path from i_tx_ready. o_rd_addr = rd_ptr. On each read, rd_ptr<=rd_ptr+1 (wraps mod 2^ADDR_W, 0x3FF -> 0x000) and remaining--. Go to DRAIN when remaining reaches 0.
  - DRAIN: wait until sent==len, i.e. the beat with o_tx_last is accepted, then go to DONE.
  - DONE: o_done=1 for exactly one cycle, o_busy<=0, return to IDLE.
- inflight: register set in the cycle after o_rd_en=1. While it is set, i_rd_data is pushed into the FIFO at the next edge.
- FIFO: depth 4, so the issue rule guarantees no overflow. Push and pop in the same cycle are legal.
- Stream: o_tx_valid = FIFO non-empty; o_tx_data = FIFO head. A beat transfers when valid&&ready. o_tx_last = valid && (sent == len-1). Data and last stay stable while valid&&!ready.
- Latency: start sampled at edge k gives o_rd_en high in cycle k+1, RAM data in cycle k+2, and first o_tx_valid in cycle k+3.
- Throughput: with ready held high, 1 byte/cycle. The last beat is accepted in cycle k+2+len, and o_done follows in the next cycle.
- Simultaneous events: i_start in the o_done cycle is ignored (state is not IDLE). A new start is accepted the cycle after o_done.

Decomposition:
- Package eth_pkg: ETH_RAM_AW=10, ETH_DW=8, ETH_LEN_W=11, enum rd_state_t {IDLE, READ, DRAIN, DONE}.
- Sub-module eth_rd_prefetch_fifo: 4-entry synchronous FIFO, depth 4 (power of 2), outputs count/empty/full, first-word-fall-through head. The top level holds the FSM, pointer and counters.

Test Plan:
1. Nominal frame: RAM[0..3]=11,22,33,44; base 0x000, len 4, ready=1. Expect rd_en in cycles k+1..k+4 with addr 0,1,2,3; beats 11,22,33,44 in k+3..k+6; last only on 44; o_done at k+7; busy low after.
2. Wrap: base 0x3FE, len 4. Expect o_rd_addr sequence 3FE,3FF,000,001 and data in that order.
3. Backpressure: len 8, ready pattern 1,0,1,0 then random. Expect every byte exactly once and in order, data held stable while stalled, fifo_count+inflight never >3, no overflow.
4. Length edges: len 0 gives o_done at k+1, no rd_en, no valid. len 1500 is clamped, giving exactly 1024 beats. len 1024 from base 0x200 with ready=1 has last accepted at k+1026.
5. Start while busy: pulse i_start mid-frame with different base/len; the active frame is unaffected. Start in the o_done cycle is ignored; start one cycle later is accepted.
6. Reset mid-frame: drop i_rst_n after 3 beats. At next edge all outputs are 0 and no o_done occurs; a new frame after release streams correctly from its base.
